tcdm_burst_reader: RTL and testbench

TCDM_BURST_READER -- requirements
Module: tcdm_burst_reader

---
 rtl/tcdm_burst_reader.sv | 181 ++++++++++++++++++
 tb/tb_tcdm_burst_reader.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tcdm_burst_reader.sv
// TCDM burst reader: fetches num_words_i consecutive 32-bit words over TCDM
// and streams them out in address order through a small response FIFO.
//
// Ports:
//   clk_i, rst_ni                    clock, async active-low reset
//   start_i, base_addr_i, num_words_i  burst command (taken in IDLE only)
//   busy_o, done_o, err_o            status (done_o one-cycle pulse, err_o sticky)
//   req_o, add_o, wen_o, wdata_o, be_o, gnt_i   TCDM request channel
//   r_valid_i, r_rdata_i, r_opc_i    TCDM response channel
//   out_valid_o, out_data_o, out_ready_i        output word stream
module tcdm_burst_reader #(
   parameter int unsigned FIFO_DEPTH = 4,
   parameter int unsigned CNT_WIDTH  = 16
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 start_i,
   input  logic [31:0]          base_addr_i,
   input  logic [CNT_WIDTH-1:0] num_words_i,
   output logic                 busy_o,
   output logic                 done_o,
   output logic                 err_o,
   output logic                 req_o,
   output logic [31:0]          add_o,
   output logic                 wen_o,
   output logic [31:0]          wdata_o,
   output logic [3:0]           be_o,
   input  logic                 gnt_i,
   input  logic                 r_valid_i,
   input  logic [31:0]          r_rdata_i,
   input  logic                 r_opc_i,
   output logic                 out_valid_o,
   output logic [31:0]          out_data_o,
   input  logic                 out_ready_i
);

   localparam int unsigned PW = $clog2(FIFO_DEPTH);
   localparam logic [CNT_WIDTH-1:0] C_ONE = CNT_WIDTH'(1);
   localparam logic [CNT_WIDTH:0] C_DEPTH = (CNT_WIDTH+1)'(FIFO_DEPTH);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DRAIN
   } state_t;

   state_t r_state;
   state_t w_state_nxt;

   logic [31:0]          r_base;
   logic [CNT_WIDTH-1:0] r_num;
   logic [CNT_WIDTH-1:0] r_issued;
   logic [CNT_WIDTH-1:0] r_received;
   logic                 r_err;
   logic                 r_done;

   logic [31:0]   r_mem [FIFO_DEPTH];
   logic [PW-1:0] r_wptr;
   logic [PW-1:0] r_rptr;
   logic [PW:0]   r_count;

   logic [CNT_WIDTH-1:0] w_outst;
   logic [CNT_WIDTH-1:0] w_issued_inc;
   logic [CNT_WIDTH:0]   w_inflight;
   logic                 w_req;
   logic                 w_acc;
   logic                 w_push;
   logic                 w_pop;
   logic                 w_start_go;
   logic                 w_start_zero;
   logic                 w_done_set;
   logic                 w_unused_addr_bits;

   assign w_unused_addr_bits = ^base_addr_i[1:0];

   assign w_outst      = r_issued - r_received;
   assign w_issued_inc = r_issued + C_ONE;
   // Words already claimed against the buffer: in flight plus buffered.
   // Requests stop when this reaches the depth, so a push never overflows
   // and the request condition can only drop through an accept.
   assign w_inflight   = {1'b0, w_outst} + (CNT_WIDTH+1)'(r_count);

   assign w_req  = (r_state == S_RUN) && (r_issued < r_num) &&
                   (w_inflight < C_DEPTH);
   assign w_acc  = w_req && gnt_i;
   // Responses with nothing outstanding (e.g. left over from before a
   // reset) are dropped.
   assign w_push = r_valid_i && (w_outst != '0);
   assign w_pop  = (r_count != '0) && out_ready_i;

   always_comb begin
      w_state_nxt  = r_state;
      w_start_go   = 1'b0;
      w_start_zero = 1'b0;
      w_done_set   = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            if (start_i) begin
               if (num_words_i != '0) begin
                  w_start_go  = 1'b1;
                  w_state_nxt = S_RUN;
               end else begin
                  w_start_zero = 1'b1;
                  w_done_set   = 1'b1;
               end
            end
         end
         S_RUN: begin
            if (w_acc && (w_issued_inc == r_num))
               w_state_nxt = S_DRAIN;
         end
         S_DRAIN: begin
            if ((r_received == r_num) && (r_count == '0)) begin
               w_state_nxt = S_IDLE;
               w_done_set  = 1'b1;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state    <= S_IDLE;
         r_base     <= '0;
         r_num      <= '0;
         r_issued   <= '0;
         r_received <= '0;
         r_err      <= 1'b0;
         r_done     <= 1'b0;
         r_wptr     <= '0;
         r_rptr     <= '0;
         r_count    <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_done  <= w_done_set;
         if (w_start_go) begin
            r_base     <= {base_addr_i[31:2], 2'b00};
            r_num      <= num_words_i;
            r_issued   <= '0;
            r_received <= '0;
         end else begin
            if (w_acc)
               r_issued <= w_issued_inc;
            if (w_push)
               r_received <= r_received + C_ONE;
         end
         if (w_start_go || w_start_zero)
            r_err <= 1'b0;
         else if (w_push && r_opc_i)
            r_err <= 1'b1;
         if (w_push)
            r_wptr <= r_wptr + PW'(1);
         if (w_pop)
            r_rptr <= r_rptr + PW'(1);
         unique case ({w_push, w_pop})
            2'b10:   r_count <= r_count + (PW+1)'(1);
            2'b01:   r_count <= r_count - (PW+1)'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // Storage needs no reset; the pointers and count define validity.
   always_ff @(posedge clk_i) begin
      if (w_push)
         r_mem[r_wptr] <= r_rdata_i;
   end

   assign busy_o      = (r_state != S_IDLE);
   assign done_o      = r_done;
   assign err_o       = r_err;
   assign req_o       = w_req;
   assign add_o       = r_base + (32'(r_issued) << 2);
   assign wen_o       = 1'b1;
   assign wdata_o     = '0;
   assign be_o        = 4'hF;
   assign out_valid_o = (r_count != '0);
   assign out_data_o  = out_valid_o ? r_mem[r_rptr] : '0;

endmodule

// File: tb/tb_tcdm_burst_reader.sv
// Bench for tcdm_burst_reader: random TCDM slave and stream sink,
// checked against a word-level model of the burst.
module tb_tcdm_burst_reader;

   localparam int DEPTH = 4;

   logic        clk_i;
   logic        rst_ni;
   logic        start_i;
   logic [31:0] base_addr_i;
   logic [15:0] num_words_i;
   logic        busy_o;
   logic        done_o;
   logic        err_o;
   logic        req_o;
   logic [31:0] add_o;
   logic        wen_o;
   logic [31:0] wdata_o;
   logic [3:0]  be_o;
   logic        gnt_i;
   logic        r_valid_i;
   logic [31:0] r_rdata_i;
   logic        r_opc_i;
   logic        out_valid_o;
   logic [31:0] out_data_o;
   logic        out_ready_i;

   tcdm_burst_reader #(
      .FIFO_DEPTH(DEPTH),
      .CNT_WIDTH (16)
   ) dut (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .start_i    (start_i),
      .base_addr_i(base_addr_i),
      .num_words_i(num_words_i),
      .busy_o     (busy_o),
      .done_o     (done_o),
      .err_o      (err_o),
      .req_o      (req_o),
      .add_o      (add_o),
      .wen_o      (wen_o),
      .wdata_o    (wdata_o),
      .be_o       (be_o),
      .gnt_i      (gnt_i),
      .r_valid_i  (r_valid_i),
      .r_rdata_i  (r_rdata_i),
      .r_opc_i    (r_opc_i),
      .out_valid_o(out_valid_o),
      .out_data_o (out_data_o),
      .out_ready_i(out_ready_i)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   typedef struct {
      logic [31:0] addr;
      int          idx;
      int          bid;
      int          due;
   } rsp_t;

   rsp_t        rsp_q[$];
   int          n_checks = 0;
   int          n_errors = 0;
   int          cyc = 0;
   int          gnt_pct = 100;
   int          rsp_pct = 100;
   int          rdy_pct = 100;
   bit          spur_en = 0;
   int          err_idx = -1;

   bit          m_active = 0;
   bit          m_done_exp = 0;
   bit          m_err = 0;
   logic [31:0] m_base = '0;
   int          m_n = 0;
   int          m_acc = 0;
   int          m_rcv = 0;
   int          m_pop = 0;
   int          m_bid = 0;
   int          m_done_seen = 0;
   int          m_first_acc = 0;
   int          m_last_acc = 0;
   bit          m_stall = 0;
   logic [31:0] m_stall_addr = '0;

   function automatic logic [31:0] mem_data(input logic [31:0] a);
      return {a[15:0], a[31:16]} ^ 32'hC0FF_EE11;
   endfunction

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)",
                  tag, got, exp, cyc);
      end
   endtask

   // One clock: check outputs, drive inputs, advance the model, clock.
   // Entered and left at a falling edge.
   task automatic cycle();
      bit          was_active;
      bit          exp_req;
      bit          fin;
      bit          rv;
      bit          acc;
      bit          pop;
      logic [31:0] exp_addr;
      was_active = m_active;
      exp_req = m_active && (m_acc < m_n) && ((m_acc - m_pop) < DEPTH);
      exp_addr = m_base + 32'(m_acc * 4);
      check("busy", 32'(busy_o), 32'(m_active));
      check("done", 32'(done_o), 32'(m_done_exp));
      check("err", 32'(err_o), 32'(m_err));
      check("ovalid", 32'(out_valid_o), 32'(m_rcv > m_pop));
      if (out_valid_o)
         check("odata", out_data_o, mem_data(m_base + 32'(m_pop * 4)));
      check("req", 32'(req_o), 32'(exp_req));
      if (req_o)
         check("addr", add_o, exp_addr);
      if (m_stall) begin
         check("stall_req", 32'(req_o), 32'd1);
         check("stall_addr", add_o, m_stall_addr);
      end
      if (done_o)
         m_done_seen++;

      gnt_i = ($urandom_range(0, 99) < gnt_pct);
      out_ready_i = ($urandom_range(0, 99) < rdy_pct);
      rv = 0;
      if (rsp_q.size() > 0 && rsp_q[0].due <= cyc &&
          $urandom_range(0, 99) < rsp_pct) begin
         rv = 1;
         r_rdata_i = mem_data(rsp_q[0].addr);
         r_opc_i = (rsp_q[0].idx == err_idx) && (rsp_q[0].bid == m_bid);
         void'(rsp_q.pop_front());
      end else if (spur_en && rsp_q.size() == 0 &&
                   $urandom_range(0, 19) == 0) begin
         rv = 1;
         r_rdata_i = $urandom;
         r_opc_i = 1'b1;
      end else begin
         r_rdata_i = $urandom;
         r_opc_i = 1'($urandom_range(0, 1));
      end
      r_valid_i = rv;

      fin = m_active && (m_acc == m_n) && (m_rcv == m_n) && (m_pop == m_n);
      acc = req_o && gnt_i;
      pop = out_valid_o && out_ready_i;
      m_stall = req_o && !gnt_i;
      m_stall_addr = add_o;
      if (rv && m_rcv < m_acc) begin
         m_rcv++;
         if (r_opc_i)
            m_err = 1;
      end
      if (acc) begin
         rsp_q.push_back('{addr: add_o, idx: m_acc, bid: m_bid, due: cyc + 1});
         if (m_acc == 0)
            m_first_acc = cyc;
         m_last_acc = cyc;
         m_acc++;
      end
      if (pop)
         m_pop++;
      m_done_exp = fin;
      if (fin)
         m_active = 0;
      if (start_i && !was_active) begin
         m_err = 0;
         if (num_words_i != 0) begin
            m_active = 1;
            m_bid++;
            m_base = {base_addr_i[31:2], 2'b00};
            m_n = int'(num_words_i);
            m_acc = 0;
            m_rcv = 0;
            m_pop = 0;
         end else begin
            m_done_exp = 1;
         end
      end

      @(posedge clk_i);
      cyc++;
      @(negedge clk_i);
      start_i = 1'b0;
      r_valid_i = 1'b0;
   endtask

   task automatic start_burst(input logic [31:0] b, input int n);
      m_done_seen = 0;
      start_i = 1'b1;
      base_addr_i = b;
      num_words_i = 16'(n);
      cycle();
   endtask

   task automatic run_idle(input int max, input bit noise);
      int k;
      k = 0;
      while ((m_active || m_done_exp) && k < max) begin
         if (noise && m_active && $urandom_range(0, 7) == 0) begin
            start_i = 1'b1;
            base_addr_i = $urandom;
            num_words_i = 16'($urandom_range(0, 8));
         end
         cycle();
         k++;
      end
      check("timeout", 32'(m_active || m_done_exp), 32'd0);
   endtask

   initial begin
      rst_ni = 1'b0;
      start_i = 1'b0;
      base_addr_i = '0;
      num_words_i = '0;
      gnt_i = 1'b0;
      r_valid_i = 1'b0;
      r_rdata_i = '0;
      r_opc_i = 1'b0;
      out_ready_i = 1'b0;
      repeat (2) @(negedge clk_i);
      check("rst_busy", 32'(busy_o), 32'd0);
      check("rst_req", 32'(req_o), 32'd0);
      check("rst_add", add_o, 32'd0);
      check("rst_ovalid", 32'(out_valid_o), 32'd0);
      check("rst_odata", out_data_o, 32'd0);
      check("wen", 32'(wen_o), 32'd1);
      check("wdata", wdata_o, 32'd0);
      check("be", 32'(be_o), 32'hF);
      rst_ni = 1'b1;
      repeat (2) cycle();

      // Full-rate burst: back-to-back accepts, one done pulse.
      gnt_pct = 100; rsp_pct = 100; rdy_pct = 100;
      start_burst(32'h1A00_0000, 8);
      run_idle(100, 0);
      check("b2b_span", 32'(m_last_acc - m_first_acc), 32'd7);
      check("b2b_pops", 32'(m_pop), 32'd8);
      check("b2b_done", 32'(m_done_seen), 32'd1);

      // Sink stalled: requests stop once the buffer budget is used.
      rdy_pct = 0;
      start_burst(32'h4000_0010, 16);
      repeat (12) cycle();
      check("bp_acc", 32'(m_acc), 32'd4);
      check("bp_req", 32'(req_o), 32'd0);
      rdy_pct = 100;
      run_idle(200, 0);
      check("bp_pops", 32'(m_pop), 32'd16);

      // Grant withheld for five cycles on the first request.
      gnt_pct = 0;
      start_burst(32'h5000_0100, 3);
      repeat (5) cycle();
      check("gnt_wait_acc", 32'(m_acc), 32'd0);
      gnt_pct = 100;
      cycle();
      check("gnt6_acc", 32'(m_acc), 32'd1);
      run_idle(100, 0);

      // Address wrap at the top of the address space.
      start_burst(32'hFFFF_FFFA, 4);
      run_idle(100, 0);
      check("wrap_pops", 32'(m_pop), 32'd4);

      // Error response on word 3 of 5, then cleared by new starts.
      err_idx = 2;
      start_burst(32'h6000_0000, 5);
      run_idle(100, 0);
      check("err_sticky", 32'(err_o), 32'd1);
      check("err_pops", 32'(m_pop), 32'd5);
      check("err_done", 32'(m_done_seen), 32'd1);
      err_idx = -1;
      start_burst(32'h6000_1000, 0);
      run_idle(10, 0);
      check("zero_done", 32'(m_done_seen), 32'd1);
      check("zero_err", 32'(err_o), 32'd0);
      start_burst(32'h6000_2000, 3);
      run_idle(100, 0);

      // Reset with two reads outstanding; late responses must vanish.
      rsp_pct = 0;
      start_burst(32'h2000_0000, 8);
      repeat (2) cycle();
      rst_ni = 1'b0;
      #1;
      check("mrst_req", 32'(req_o), 32'd0);
      check("mrst_add", add_o, 32'd0);
      check("mrst_busy", 32'(busy_o), 32'd0);
      check("mrst_done", 32'(done_o), 32'd0);
      check("mrst_err", 32'(err_o), 32'd0);
      check("mrst_ovalid", 32'(out_valid_o), 32'd0);
      check("mrst_odata", out_data_o, 32'd0);
      m_active = 0; m_done_exp = 0; m_err = 0; m_stall = 0;
      m_n = 0; m_acc = 0; m_rcv = 0; m_pop = 0;
      @(negedge clk_i);
      cyc++;
      rst_ni = 1'b1;
      rsp_pct = 100;
      for (int i = 0; i < 20 && rsp_q.size() > 0; i++)
         cycle();
      start_burst(32'h3000_0000, 6);
      run_idle(100, 0);
      check("post_rst_pops", 32'(m_pop), 32'd6);

      // Random bursts with random handshakes, spurious responses
      // and ignored start pulses while busy.
      spur_en = 1;
      for (int b = 0; b < 25; b++) begin
         int n;
         gnt_pct = $urandom_range(30, 100);
         rsp_pct = $urandom_range(30, 100);
         rdy_pct = $urandom_range(20, 100);
         n = $urandom_range(0, 40);
         err_idx = ($urandom_range(0, 3) == 0) ? $urandom_range(0, n) : -1;
         start_burst($urandom, n);
         run_idle(3000, 1);
         check("rnd_pops", 32'(m_pop), 32'(n == 0 ? m_pop : n));
         check("rnd_done", 32'(m_done_seen), 32'd1);
      end

      $display("Simulation finished: %0d checks, %0d errors",
               n_checks, n_errors);
      $finish;
   end

endmodule
